apb_pid_slave: RTL and testbench
================================

Name: apb_pid_slave

Overview:
- APB3/APB4 completer that sits directly downstream of the AHB-to-APB bridge, on its PSEL/PENABLE/PREADY/PSLVERR interface.
- Holds the PID accelerator's coefficient and setpoint registers.
- A write to FEEDBACK triggers a sequential, single-multiplier PID computation.
- Inserts APB wait states when an access conflicts with an in-progress computation, and raises PSLVERR on illegal accesses.

Parameters:
- ADDRWIDTH, 12, APB address width; only PADDR[4:2] is decoded, and PADDR[ADDRWIDTH-1:5] must be zero.
- DATAW, 16, signed width of coefficients, samples and output.
- FRAC, 8, number of fractional bits in the coefficients (Q(DATAW-FRAC).FRAC).
- INTW, 24, signed integrator width.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  write when 1
- PADDR  in  ADDRWIDTH  byte address
- PWDATA  in  32  write data
- PSTRB  in  4  byte strobes
- PPROT  in  3  protection
- PRDATA  out  32  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  error response, valid only when PREADY=1
- irq  out  1  level interrupt, equal to DONE & IE

Behaviour:
- Reset and clock: HRESETn is asynchronous, active-low; clock is HCLK.
- Reset values: all registers 0, FSM in IDLE, irq=0, PRDATA=0. When PSEL=0, PREADY=1 and PSLVERR=0.
- Register map:
  - 0x00 CTRL: [0] EN, [1] CLR (write-1 pulse, reads 0), [2] IE.
  - 0x04 STATUS: [0] BUSY (RO), [1] DONE (W1C), [2] SAT (RO, result of the last computation).
  - 0x08 KP, 0x0C KI, 0x10 KD, 0x14 SETPOINT: RW, DATAW bits, sign-extended on read.
  - 0x18 FEEDBACK: RW.
  - 0x1C OUTPUT: RO.
- Transfer commit: a transfer commits when PSEL & PENABLE & PREADY.
- Write rules:
  - PSTRB must be 4'hF; otherwise PSLVERR=1 and no register update.
  - Writes to a read-only offset or an unmapped address give PSLVERR=1.
  - Reads of unmapped addresses give PSLVERR=1 and PRDATA=0.
- Wait states:
  - While BUSY, any write and any read of OUTPUT hold PREADY=0 until BUSY falls.
  - Reads of STATUS never stall.
  - PRDATA is driven combinationally during the access phase.
- Compute trigger: a committed FEEDBACK write with EN=1 starts the FSM on the next cycle. With EN=0 it only stores the value.
- FSM sequence: IDLE → ERR → MULP → MULI → MULD → OUT → IDLE. One state per cycle, so BUSY is high for exactly 5 cycles.
  - ERR: e = SP − FB (DATAW+1 bits); integ = sat_INTW(integ + e); d = e − e_prev.
  - MULP: acc = KP·e.
  - MULI: acc += KI·integ.
  - MULD: acc += KD·d.
  - OUT: OUTPUT = sat_DATAW(acc >>> FRAC) (arithmetic shift); SAT = saturated; e_prev = e; DONE=1.
- Accumulator width: wide enough that no overflow occurs before the final saturation.
- CLR: clears integ and e_prev. It is a write, so it stalls while BUSY and never lands mid-computation.
- Simultaneous DONE set and DONE W1C in the same cycle: set wins.
- EN cleared mid-computation: the current computation still completes.
- Reset mid-computation: aborts immediately to reset values.

Optional Feature:
- Macro: APB_PID_PROT_EN.
- Defined: writes with PPROT[0]=0 (unprivileged) to CTRL, KP, KI or KD return PSLVERR=1 with no update. All reads, and writes to SETPOINT, FEEDBACK and STATUS, are unaffected.
- Undefined: PPROT is ignored and the port remains present.

Decomposition:
- Package apb_pid_pkg holds:
  - register offset localparams;
  - CTRL/STATUS bit indices;
  - the FSM state enum (IDLE, ERR, MULP, MULI, MULD, OUT);
  - the saturation function.
- One sub-module, pid_engine, contains the FSM, integrator, e_prev, the single multiplier and the accumulator.
  - Inputs: start, clr, coefficients, SP, FB.
  - Outputs: busy, done_pulse, out, sat.
- The top level contains the APB decode, wait-state and error logic, and the register file.

Test Plan:
- Proportional only: KP=0x0100, KI=KD=0, EN=1, SP=100, FB=40 → BUSY for 5 cycles, then OUTPUT=60, DONE=1, SAT=0.
- Integrator: KI=0x0100, KP=KD=0, SP=10; write FB=0 twice → OUTPUT=10, then 20. After CLR, FB=0 again → OUTPUT=10.
- Saturation: KP=0x7FFF, SP=0x7FFF, FB=0x8000 → OUTPUT=0x7FFF, SAT=1. Negative mirror case → 0x8000.
- Stall: write KP while BUSY → PREADY=0 until BUSY falls, then commit. STATUS read during BUSY → PREADY=1 immediately with BUSY=1.
- Errors: read 0x40 → PSLVERR=1, PRDATA=0. Write OUTPUT → PSLVERR=1. Write KP with PSTRB=4'h3 → PSLVERR=1 and KP unchanged. With the macro defined, write KP with PPROT=0 → PSLVERR=1.
- IRQ and reset: IE=1 → irq rises with DONE; W1C of DONE drops irq. HRESETn asserted during MULI → BUSY=0, OUTPUT=0, and the FSM is in IDLE after release.

Source files
------------

// File: rtl/apb_pid_pkg.sv
// -----------------------------------------------------------------------------
// apb_pid_pkg
// Shared definitions for the APB PID accelerator:
//   - register word offsets (PADDR[4:2])
//   - CTRL / STATUS bit positions
//   - PID engine FSM state encoding
//   - generic signed saturation helpers, evaluated on a 64-bit carrier
// Optional feature macro used by this design: APB_PID_PROT_EN (see apb_pid_slave).
// -----------------------------------------------------------------------------
package apb_pid_pkg;

    // Word offsets, i.e. PADDR[4:2]
    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_KP     = 3'd2;
    localparam logic [2:0] OFF_KI     = 3'd3;
    localparam logic [2:0] OFF_KD     = 3'd4;
    localparam logic [2:0] OFF_SP     = 3'd5;
    localparam logic [2:0] OFF_FB     = 3'd6;
    localparam logic [2:0] OFF_OUT    = 3'd7;

    // CTRL bits
    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;
    localparam int CTRL_IE  = 2;

    // STATUS bits
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_SAT  = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ERR  = 3'd1,
        MULP = 3'd2,
        MULI = 3'd3,
        MULD = 3'd4,
        OUT  = 3'd5
    } pid_state_e;

    // Width of the carrier used by the saturation helpers; every operand the
    // engine saturates is narrower than this.
    localparam int SAT_W = 64;

    // Clamp a signed value to the range of a w-bit two's complement number.
    function automatic logic signed [SAT_W-1:0] sat_clamp(input logic signed [SAT_W-1:0] v,
                                                         input int unsigned            w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

    // True when sat_clamp would alter the value.
    function automatic logic sat_hit(input logic signed [SAT_W-1:0] v,
                                     input int unsigned            w);
        return sat_clamp(v, w) != v;
    endfunction

endpackage

// File: rtl/pid_engine.sv
// -----------------------------------------------------------------------------
// pid_engine
// Sequential PID computation around one shared signed multiplier.
// Sequence: IDLE -> ERR -> MULP -> MULI -> MULD -> OUT -> IDLE (one cycle each).
//   ERR : e = sp - fb, integ = sat(integ + e), d = e - e_prev
//   MULP: acc  = kp * e
//   MULI: acc += ki * integ
//   MULD: acc += kd * d
//   OUT : out = sat(acc >>> FRAC), sat flag, e_prev = e
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i              begin a computation (sampled in IDLE only)
//   clr_i                clear integrator and e_prev (sampled in IDLE only)
//   kp_i/ki_i/kd_i       coefficients, Q(DATAW-FRAC).FRAC
//   sp_i, fb_i           setpoint and feedback samples
//   busy_o               high while a computation is in flight
//   done_pulse_o         high during the OUT cycle; results land at its end
//   out_o, sat_o         last result and whether it was clamped
// -----------------------------------------------------------------------------
module pid_engine
    import apb_pid_pkg::*;
#(
    parameter int DATAW = 16,
    parameter int FRAC  = 8,
    parameter int INTW  = 24
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    clr_i,
    input  logic signed [DATAW-1:0] kp_i,
    input  logic signed [DATAW-1:0] ki_i,
    input  logic signed [DATAW-1:0] kd_i,
    input  logic signed [DATAW-1:0] sp_i,
    input  logic signed [DATAW-1:0] fb_i,
    output logic                    busy_o,
    output logic                    done_pulse_o,
    output logic signed [DATAW-1:0] out_o,
    output logic                    sat_o
);

    localparam int EW    = DATAW + 1;                  // error
    localparam int DW    = DATAW + 2;                  // derivative term
    localparam int OPW   = (INTW > DW) ? INTW : DW;    // shared multiplier B operand
    localparam int PRODW = DATAW + OPW;
    // Three products summed: two guard bits keep the sum exact.
    localparam int ACCW  = PRODW + 2;

    pid_state_e              state_q;
    logic signed [EW-1:0]    e_q;
    logic signed [EW-1:0]    eprev_q;
    logic signed [INTW-1:0]  integ_q;
    logic signed [DW-1:0]    d_q;
    logic signed [ACCW-1:0]  acc_q;
    logic signed [DATAW-1:0] out_q;
    logic                    sat_q;

    logic signed [EW-1:0]    e_d;
    logic signed [INTW:0]    integ_sum;
    logic signed [DATAW-1:0] mul_a;
    logic signed [OPW-1:0]   mul_b;
    logic signed [PRODW-1:0] prod;
    logic signed [ACCW-1:0]  acc_shift;

    assign e_d       = EW'(sp_i) - EW'(fb_i);
    assign integ_sum = (INTW+1)'(integ_q) + (INTW+1)'(e_d);
    assign acc_shift = acc_q >>> FRAC;

    // Operand steering for the single multiplier.
    always_comb begin
        mul_a = kp_i;
        mul_b = OPW'(e_q);
        case (state_q)
            MULI: begin
                mul_a = ki_i;
                mul_b = OPW'(integ_q);
            end
            MULD: begin
                mul_a = kd_i;
                mul_b = OPW'(d_q);
            end
            default: ;
        endcase
    end

    assign prod = PRODW'(mul_a) * PRODW'(mul_b);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            e_q     <= '0;
            eprev_q <= '0;
            integ_q <= '0;
            d_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_i) begin
                        integ_q <= '0;
                        eprev_q <= '0;
                    end
                    if (start_i)
                        state_q <= ERR;
                end
                ERR: begin
                    e_q     <= e_d;
                    integ_q <= INTW'(sat_clamp(SAT_W'(integ_sum), INTW));
                    d_q     <= DW'(e_d) - DW'(eprev_q);
                    state_q <= MULP;
                end
                MULP: begin
                    acc_q   <= ACCW'(prod);
                    state_q <= MULI;
                end
                MULI: begin
                    acc_q   <= acc_q + ACCW'(prod);
                    state_q <= MULD;
                end
                MULD: begin
                    acc_q   <= acc_q + ACCW'(prod);
                    state_q <= OUT;
                end
                OUT: begin
                    out_q   <= DATAW'(sat_clamp(SAT_W'(acc_shift), DATAW));
                    sat_q   <= sat_hit(SAT_W'(acc_shift), DATAW);
                    eprev_q <= e_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign done_pulse_o = (state_q == OUT);
    assign out_o        = out_q;
    assign sat_o        = sat_q;

endmodule

// File: rtl/apb_pid_slave.sv
// -----------------------------------------------------------------------------
// apb_pid_slave
// APB3/APB4 completer holding the PID accelerator registers; a committed write
// to FEEDBACK with CTRL.EN set launches one computation in pid_engine.
// Register map (word offsets PADDR[4:2], PADDR[ADDRWIDTH-1:5] must be zero):
//   0x00 CTRL   [0] EN, [1] CLR (write-1 pulse, reads 0), [2] IE
//   0x04 STATUS [0] BUSY (RO), [1] DONE (W1C), [2] SAT (RO)
//   0x08 KP, 0x0C KI, 0x10 KD, 0x14 SETPOINT, 0x18 FEEDBACK (RW, sign-extended)
//   0x1C OUTPUT (RO, sign-extended)
// Ports:
//   HCLK, HRESETn         clock, asynchronous active-low reset
//   PSEL..PPROT           APB request
//   PRDATA, PREADY,
//   PSLVERR               APB response (PRDATA combinational in access phase)
//   irq                   DONE & IE
// While the engine is busy every write and every OUTPUT read is held with
// PREADY=0; STATUS and other reads complete immediately.
// Optional macro APB_PID_PROT_EN: unprivileged (PPROT[0]=0) writes to CTRL,
// KP, KI, KD are rejected with PSLVERR. Without it PPROT is ignored.
// -----------------------------------------------------------------------------
module apb_pid_slave
    import apb_pid_pkg::*;
#(
    parameter int ADDRWIDTH = 12,
    parameter int DATAW     = 16,
    parameter int FRAC      = 8,
    parameter int INTW      = 24
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [ADDRWIDTH-1:0] PADDR,
    input  logic [31:0]          PWDATA,
    input  logic [3:0]           PSTRB,
    input  logic [2:0]           PPROT,
    output logic [31:0]          PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    output logic                 irq
);

    logic                    en_q, en_d;
    logic                    ie_q, ie_d;
    logic                    done_q, done_d;
    logic signed [DATAW-1:0] kp_q, kp_d;
    logic signed [DATAW-1:0] ki_q, ki_d;
    logic signed [DATAW-1:0] kd_q, kd_d;
    logic signed [DATAW-1:0] sp_q, sp_d;
    logic signed [DATAW-1:0] fb_q, fb_d;

    logic                    busy;
    logic                    done_pulse;
    logic signed [DATAW-1:0] out_val;
    logic                    sat_flag;

    logic [2:0]  off;
    logic        addr_ok;
    logic        acc_phase;
    logic        stall;
    logic        wr_err;
    logic        xfer_err;
    logic        wr_en;
    logic        start;
    logic        clr;
    logic [31:0] rdata;
    logic        unused_bits;

    assign off       = PADDR[4:2];
    assign addr_ok   = (PADDR[ADDRWIDTH-1:5] == '0);
    assign acc_phase = PSEL & PENABLE;

    // Hold writes and OUTPUT reads until the running computation retires.
    assign stall  = PSEL & busy & (PWRITE | (addr_ok & (off == OFF_OUT)));
    assign PREADY = ~stall;

    always_comb begin
        wr_err = ~addr_ok | (PSTRB != 4'hF) | (off == OFF_OUT);
`ifdef APB_PID_PROT_EN
        if (!PPROT[0] && (off == OFF_CTRL || off == OFF_KP || off == OFF_KI || off == OFF_KD))
            wr_err = 1'b1;
`endif
    end

    assign xfer_err = PWRITE ? wr_err : ~addr_ok;
    assign PSLVERR  = acc_phase & PREADY & xfer_err;
    assign wr_en    = acc_phase & PREADY & PWRITE & ~wr_err;

    assign start = wr_en & (off == OFF_FB) & en_q;
    assign clr   = wr_en & (off == OFF_CTRL) & PWDATA[CTRL_CLR];

    always_comb begin
        en_d   = en_q;
        ie_d   = ie_q;
        done_d = done_q;
        kp_d   = kp_q;
        ki_d   = ki_q;
        kd_d   = kd_q;
        sp_d   = sp_q;
        fb_d   = fb_q;
        if (wr_en) begin
            case (off)
                OFF_CTRL: begin
                    en_d = PWDATA[CTRL_EN];
                    ie_d = PWDATA[CTRL_IE];
                end
                OFF_STATUS: if (PWDATA[STAT_DONE]) done_d = 1'b0;
                OFF_KP:     kp_d = $signed(PWDATA[DATAW-1:0]);
                OFF_KI:     ki_d = $signed(PWDATA[DATAW-1:0]);
                OFF_KD:     kd_d = $signed(PWDATA[DATAW-1:0]);
                OFF_SP:     sp_d = $signed(PWDATA[DATAW-1:0]);
                OFF_FB:     fb_d = $signed(PWDATA[DATAW-1:0]);
                default: ;
            endcase
        end
        // A completion in the same cycle as a DONE clear takes priority.
        if (done_pulse)
            done_d = 1'b1;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            en_q   <= 1'b0;
            ie_q   <= 1'b0;
            done_q <= 1'b0;
            kp_q   <= '0;
            ki_q   <= '0;
            kd_q   <= '0;
            sp_q   <= '0;
            fb_q   <= '0;
        end else begin
            en_q   <= en_d;
            ie_q   <= ie_d;
            done_q <= done_d;
            kp_q   <= kp_d;
            ki_q   <= ki_d;
            kd_q   <= kd_d;
            sp_q   <= sp_d;
            fb_q   <= fb_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL: begin
                rdata[CTRL_EN] = en_q;
                rdata[CTRL_IE] = ie_q;
            end
            OFF_STATUS: begin
                rdata[STAT_BUSY] = busy;
                rdata[STAT_DONE] = done_q;
                rdata[STAT_SAT]  = sat_flag;
            end
            OFF_KP:  rdata = 32'(kp_q);
            OFF_KI:  rdata = 32'(ki_q);
            OFF_KD:  rdata = 32'(kd_q);
            OFF_SP:  rdata = 32'(sp_q);
            OFF_FB:  rdata = 32'(fb_q);
            OFF_OUT: rdata = 32'(out_val);
            default: rdata = '0;
        endcase
    end

    assign PRDATA = (acc_phase & ~PWRITE & addr_ok) ? rdata : 32'd0;
    assign irq    = done_q & ie_q;

    // Byte-lane bits [1:0], the upper write-data lanes and (by default) PPROT
    // carry no information for this block.
    assign unused_bits = ^{PADDR[1:0], PWDATA[31:DATAW], PPROT};

    pid_engine #(
        .DATAW (DATAW),
        .FRAC  (FRAC),
        .INTW  (INTW)
    ) u_engine (
        .clk_i        (HCLK),
        .rst_ni       (HRESETn),
        .start_i      (start),
        .clr_i        (clr),
        .kp_i         (kp_q),
        .ki_i         (ki_q),
        .kd_i         (kd_q),
        .sp_i         (sp_q),
        .fb_i         (fb_q),
        .busy_o       (busy),
        .done_pulse_o (done_pulse),
        .out_o        (out_val),
        .sat_o        (sat_flag)
    );

endmodule

// File: tb/tb_apb_pid_slave.sv
module tb_apb_pid_slave;

    localparam logic [11:0] A_CTRL = 12'h000;
    localparam logic [11:0] A_STAT = 12'h004;
    localparam logic [11:0] A_KP   = 12'h008;
    localparam logic [11:0] A_KI   = 12'h00C;
    localparam logic [11:0] A_KD   = 12'h010;
    localparam logic [11:0] A_SP   = 12'h014;
    localparam logic [11:0] A_FB   = 12'h018;
    localparam logic [11:0] A_OUT  = 12'h01C;

`ifdef APB_PID_PROT_EN
    localparam logic        PROT_ERR = 1'b1;
    localparam logic [31:0] PROT_KP  = 32'h0000_0100;
`else
    localparam logic        PROT_ERR = 1'b0;
    localparam logic [31:0] PROT_KP  = 32'h0000_0200;
`endif

    logic        HCLK;
    logic        HRESETn;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        irq;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    apb_pid_slave dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PSTRB   (PSTRB),
        .PPROT   (PPROT),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .irq     (irq)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot,
                       output logic [31:0] rdata, output logic err, output int waits);
        @(negedge HCLK);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wdata;
        PSTRB   = strb;
        PPROT   = prot;
        @(negedge HCLK);
        PENABLE = 1'b1;
        #1;
        waits = 0;
        while (!PREADY && waits < 50) begin
            @(negedge HCLK);
            #1;
            waits++;
        end
        if (!PREADY) begin
            n_cmp++;
            n_fail++;
            $display("FAIL apb_timeout addr=%h: PREADY still %b after %0d cycles, required 1", addr, PREADY, waits);
        end
        rdata = PRDATA;
        err   = PSLVERR;
        @(posedge HCLK);
        #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        logic [31:0] rd_unused;
        logic        err;
        int          waits;
        apb(1'b1, addr, data, 4'hF, 3'b001, rd_unused, err, waits);
        chk($sformatf("wr_err@%h", addr), {31'b0, err}, 32'd0);
    endtask

    task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] data;
        logic        err;
        int          waits;
        apb(1'b0, addr, 32'd0, 4'h0, 3'b001, data, err, waits);
        chk(name, data, exp);
    endtask

    task automatic add(input logic w, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p,
                       input logic [31:0] er, input logic ee);
        vec_t v;
        v.wr = w; v.addr = a; v.wdata = d; v.strb = s; v.prot = p;
        v.exp_rdata = er; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] data;
        logic        err;
        int          waits;

        n_cmp   = 0;
        n_fail  = 0;
        HRESETn = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        PSTRB   = '0;
        PPROT   = '0;

        // register access / error vectors (EN=0 throughout)
        add(1, A_KP,    32'h0000_0100, 4'hF, 3'b001, 32'h0,          1'b0);
        add(0, A_CTRL,  32'h0,         4'h0, 3'b001, 32'h0,          1'b0);
        add(0, A_STAT,  32'h0,         4'h0, 3'b001, 32'h0,          1'b0);
        add(0, A_OUT,   32'h0,         4'h0, 3'b001, 32'h0,          1'b0);
        add(0, A_KP,    32'h0,         4'h0, 3'b001, 32'h0000_0100,  1'b0);
        add(1, A_KI,    32'h0000_FFFF, 4'hF, 3'b001, 32'h0,          1'b0);
        add(0, A_KI,    32'h0,         4'h0, 3'b001, 32'hFFFF_FFFF,  1'b0);
        add(1, A_KI,    32'h0,         4'hF, 3'b001, 32'h0,          1'b0);
        add(1, A_KD,    32'h0000_ABCD, 4'hF, 3'b001, 32'h0,          1'b0);
        add(0, A_KD,    32'h0,         4'h0, 3'b001, 32'hFFFF_ABCD,  1'b0);
        add(1, A_KD,    32'h0,         4'hF, 3'b001, 32'h0,          1'b0);
        add(1, A_SP,    32'd100,       4'hF, 3'b001, 32'h0,          1'b0);
        add(0, A_SP,    32'h0,         4'h0, 3'b001, 32'd100,        1'b0);
        add(0, 12'h040, 32'h0,         4'h0, 3'b001, 32'h0,          1'b1);
        add(0, 12'h020, 32'h0,         4'h0, 3'b001, 32'h0,          1'b1);
        add(1, A_OUT,   32'h0000_1234, 4'hF, 3'b001, 32'h0,          1'b1);
        add(0, A_OUT,   32'h0,         4'h0, 3'b001, 32'h0,          1'b0);
        add(1, A_KP,    32'h0000_0055, 4'h3, 3'b001, 32'h0,          1'b1);
        add(0, A_KP,    32'h0,         4'h0, 3'b001, 32'h0000_0100,  1'b0);
        add(1, A_KP,    32'h0000_0200, 4'hF, 3'b000, 32'h0,          PROT_ERR);
        add(0, A_KP,    32'h0,         4'h0, 3'b000, PROT_KP,        1'b0);
        add(1, A_KP,    32'h0000_0100, 4'hF, 3'b001, 32'h0,          1'b0);
        add(1, A_SP,    32'd100,       4'hF, 3'b000, 32'h0,          1'b0);
        add(1, A_FB,    32'd40,        4'hF, 3'b001, 32'h0,          1'b0);
        add(0, A_FB,    32'h0,         4'h0, 3'b001, 32'd40,         1'b0);
        add(0, A_STAT,  32'h0,         4'h0, 3'b001, 32'h0,          1'b0);
        add(1, 12'h044, 32'h0000_0002, 4'hF, 3'b001, 32'h0,          1'b1);
        add(1, A_CTRL,  32'h0000_0005, 4'hF, 3'b001, 32'h0,          1'b0);
        add(0, A_CTRL,  32'h0,         4'h0, 3'b001, 32'h0000_0005,  1'b0);

        // reset state
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_pready",  {31'b0, PREADY},  32'd1);
        chk("rst_pslverr", {31'b0, PSLVERR}, 32'd0);
        chk("rst_prdata",  PRDATA,           32'd0);
        chk("rst_irq",     {31'b0, irq},     32'd0);
        HRESETn = 1'b1;

        foreach (vecs[i]) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].prot, data, err, waits);
            if (!vecs[i].wr)
                chk($sformatf("vec%0d_rdata", i), data, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
        end

        // proportional: KP=1.0, SP=100, FB=40; write right behind it stalls
        wr(A_FB, 32'd40);
        apb(1'b1, A_KP, 32'h0000_0100, 4'hF, 3'b001, data, err, waits);
        chk("p_stall_waits", waits, 32'd4);
        chk("p_stall_err",   {31'b0, err}, 32'd0);
        chk("p_irq_set",     {31'b0, irq}, 32'd1);
        rd("p_status", A_STAT, 32'h2);
        rd("p_output", A_OUT,  32'd60);
        rd("p_kp",     A_KP,   32'h0000_0100);
        wr(A_STAT, 32'h2);
        chk("p_irq_clr", {31'b0, irq}, 32'd0);
        rd("p_status_w1c", A_STAT, 32'h0);

        // integrator: KI=1.0, SP=10, FB=0 repeatedly, CLR in between
        wr(A_KP, 32'h0);
        wr(A_KI, 32'h0000_0100);
        wr(A_SP, 32'd10);
        wr(A_CTRL, 32'h7);
        rd("i_ctrl", A_CTRL, 32'h5);
        wr(A_FB, 32'd0);
        apb(1'b0, A_STAT, 32'h0, 4'h0, 3'b001, data, err, waits);
        chk("i_stat_nowait", waits, 32'd0);
        chk("i_stat_busy",   data,  32'h1);
        rd("i_out1", A_OUT, 32'd10);
        wr(A_FB, 32'd0);
        apb(1'b1, A_STAT, 32'h2, 4'hF, 3'b001, data, err, waits);
        chk("i_w1c_waits", waits, 32'd4);
        rd("i_stat_after_w1c", A_STAT, 32'h0);
        rd("i_out2", A_OUT, 32'd20);
        wr(A_CTRL, 32'h7);
        wr(A_FB, 32'd0);
        rd("i_out_clr", A_OUT, 32'd10);

        // saturation, positive then negative
        wr(A_CTRL, 32'h7);
        wr(A_KI, 32'h0);
        wr(A_KP, 32'h0000_7FFF);
        wr(A_SP, 32'h0000_7FFF);
        wr(A_FB, 32'h0000_8000);
        rd("s_out_pos",  A_OUT,  32'h0000_7FFF);
        rd("s_stat_pos", A_STAT, 32'h6);
        rd("s_fb_sext",  A_FB,   32'hFFFF_8000);
        wr(A_SP, 32'h0000_8000);
        wr(A_FB, 32'h0000_7FFF);
        rd("s_out_neg",  A_OUT,  32'hFFFF_8000);
        rd("s_stat_neg", A_STAT, 32'h6);

        // reset while the engine is in MULI
        wr(A_FB, 32'd0);
        @(posedge HCLK);
        @(posedge HCLK);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("r_irq",    {31'b0, irq},    32'd0);
        chk("r_pready", {31'b0, PREADY}, 32'd1);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        rd("r_status", A_STAT, 32'h0);
        rd("r_output", A_OUT,  32'h0);
        rd("r_kp",     A_KP,   32'h0);
        rd("r_ctrl",   A_CTRL, 32'h0);

        // fresh computation after reset runs the full sequence again
        wr(A_KP, 32'h0000_0100);
        wr(A_SP, 32'd100);
        wr(A_CTRL, 32'h1);
        wr(A_FB, 32'd40);
        apb(1'b1, A_KD, 32'h0, 4'hF, 3'b001, data, err, waits);
        chk("r2_stall_waits", waits, 32'd4);
        rd("r2_output", A_OUT,  32'd60);
        rd("r2_status", A_STAT, 32'h2);
        chk("r2_irq_ie0", {31'b0, irq}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
